six_bit_accumulator: RTL and testbench

//  Multi-operand accumulator wrapped around six_bit_ripple_carry_adder.
//  - Feeds the adder: drives a, b, carry_in.
//  - Consumes its sum and carry_out to build a running total.
//  - Accepts a stream of 6-bit operands over a valid/ready handshake.
//  - Presents the final 6-bit total plus a sticky overflow flag over an output handshake.

---
 rtl/six_bit_accumulator.sv | 85 ++++++++
 tb/tb_six_bit_accumulator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/six_bit_accumulator.sv
// Multi-operand accumulator that drives an external 6-bit ripple-carry adder.
// Takes operands over a valid/ready stream and presents the burst total, sticky overflow and count.
module six_bit_accumulator #(
  parameter int unsigned MAX_OPS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_data,
  input  logic       in_last,
  output logic [5:0] adder_a,
  output logic [5:0] adder_b,
  output logic       adder_cin,
  input  logic [5:0] adder_sum,
  input  logic       adder_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_sum,
  output logic       out_overflow,
  output logic [3:0] out_count
);

  localparam logic [3:0] LP_MAX = 4'(MAX_OPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_acc;
  logic       r_ovf;
  logic [3:0] r_count;
  logic [3:0] w_count_inc;
  logic       w_accept;
  logic       w_final;

  assign in_ready    = (r_state != S_DONE);
  assign out_valid   = (r_state == S_DONE);
  assign w_accept    = in_valid & in_ready;
  assign w_count_inc = r_count + 4'd1;
  // Count is 0 in IDLE, so this also covers MAX_OPS==1 on the first operand.
  assign w_final     = in_last | (w_count_inc == LP_MAX);

  assign adder_a   = r_acc;
  assign adder_b   = in_data;
  assign adder_cin = 1'b0;

  assign out_sum      = r_acc;
  assign out_overflow = r_ovf;
  assign out_count    = r_count;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: if (w_accept) w_next = w_final ? S_DONE : S_ACCUM;
      S_DONE:          if (out_ready) w_next = S_IDLE;
      default:         w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_acc   <= adder_sum;
        r_ovf   <= r_ovf | adder_cout;
        r_count <= w_count_inc;
      end else if ((r_state == S_DONE) && out_ready) begin
        r_acc   <= '0;
        r_ovf   <= 1'b0;
        r_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_six_bit_accumulator.sv
// Directed bench for six_bit_accumulator with a behavioural adder and a result scoreboard.
module tb_six_bit_accumulator;

  localparam int unsigned MAXOPS = 15;

  typedef struct {
    logic [5:0] sum;
    logic       ovf;
    logic [3:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       in_last;
  logic [5:0] adder_a;
  logic [5:0] adder_b;
  logic       adder_cin;
  logic [5:0] adder_sum;
  logic       adder_cout;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_sum;
  logic       out_overflow;
  logic [3:0] out_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  exp_t        sb[$];
  logic [5:0]  m_acc;
  logic        m_ovf;
  logic [3:0]  m_cnt;

  always #5 clk = ~clk;

  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {6'd0, adder_cin};

  six_bit_accumulator #(.MAX_OPS(MAXOPS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .adder_a     (adder_a),
    .adder_b     (adder_b),
    .adder_cin   (adder_cin),
    .adder_sum   (adder_sum),
    .adder_cout  (adder_cout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_overflow(out_overflow),
    .out_count   (out_count)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_acc = '0;
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask

  // Offer one operand; it must be accepted on the next edge.
  task automatic send(input logic [5:0] d, input logic last);
    logic [6:0] s;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    check("in_ready_on_send", {7'd0, in_ready}, 8'd1);
    tick();
    s     = {1'b0, m_acc} + {1'b0, d};
    m_acc = s[5:0];
    m_ovf = m_ovf | s[6];
    m_cnt = m_cnt + 4'd1;
    if (last || (m_cnt == 4'(MAXOPS))) sb.push_back('{sum: m_acc, ovf: m_ovf, cnt: m_cnt});
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Pop the scoreboard when the result is presented; out_valid must already be high.
  task automatic expect_result(input string tag);
    exp_t e;
    int unsigned waited = 0;
    check({tag, "_latency"}, {7'd0, out_valid}, 8'd1);
    while (!out_valid && waited < 8) begin
      tick();
      waited++;
    end
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_sum"},      {2'd0, out_sum},      {2'd0, e.sum});
      check({tag, "_overflow"}, {7'd0, out_overflow}, {7'd0, e.ovf});
      check({tag, "_count"},    {4'd0, out_count},    {4'd0, e.cnt});
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    model_clear();
    check({tag, "_idle_valid"}, {7'd0, out_valid}, 8'd0);
    check({tag, "_idle_ready"}, {7'd0, in_ready},  8'd1);
    check({tag, "_idle_sum"},   {2'd0, out_sum},   8'd0);
    check({tag, "_idle_count"}, {4'd0, out_count}, 8'd0);
  endtask

  initial begin
    // T1: reset with in_valid asserted
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 6'd7;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();
    tick();
    tick();
    check("rst_in_ready",  {7'd0, in_ready},     8'd1);
    check("rst_out_valid", {7'd0, out_valid},    8'd0);
    check("rst_sum",       {2'd0, out_sum},      8'd0);
    check("rst_overflow",  {7'd0, out_overflow}, 8'd0);
    check("rst_count",     {4'd0, out_count},    8'd0);
    check("rst_cin",       {7'd0, adder_cin},    8'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    check("post_rst_count", {4'd0, out_count}, 8'd0);

    // T2: single pair
    send(6'b101010, 1'b0);
    check("t2_adder_a", {2'd0, adder_a}, 8'h2a);
    send(6'b010101, 1'b1);
    expect_result("t2");
    release_result("t2");

    // T3: sticky overflow
    send(6'd63, 1'b0);
    send(6'd1,  1'b0);
    send(6'd5,  1'b1);
    expect_result("t3");
    release_result("t3");

    // T4: forced completion at MAX_OPS
    for (int i = 0; i < 15; i++) send(6'd1, 1'b0);
    check("t4_in_ready", {7'd0, in_ready}, 8'd0);
    expect_result("t4");

    // T5: backpressure with a pending operand
    in_valid = 1'b1;
    in_data  = 6'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_valid", {7'd0, out_valid}, 8'd1);
      check("t5_hold_ready", {7'd0, in_ready},  8'd0);
      check("t5_hold_sum",   {2'd0, out_sum},   8'd15);
      check("t5_hold_count", {4'd0, out_count}, 8'd15);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    model_clear();
    check("t5_idle_ready", {7'd0, in_ready},  8'd1);
    check("t5_idle_count", {4'd0, out_count}, 8'd0);
    send(6'd9, 1'b0);
    send(6'd0, 1'b1);
    expect_result("t5");
    release_result("t5");

    // T6: mid-burst reset, with out_ready high outside DONE
    out_ready = 1'b1;
    send(6'd40, 1'b0);
    send(6'd40, 1'b0);
    send(6'd6,  1'b0);
    check("t6_mid_count", {4'd0, out_count}, 8'd3);
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check("t6_rst_count", {4'd0, out_count},    8'd0);
    check("t6_rst_sum",   {2'd0, out_sum},      8'd0);
    check("t6_rst_ovf",   {7'd0, out_overflow}, 8'd0);
    check("t6_rst_valid", {7'd0, out_valid},    8'd0);
    send(6'd2, 1'b0);
    send(6'd3, 1'b1);
    expect_result("t6");
    release_result("t6");

    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
